ps2_key_fifo: RTL
=================

Name: ps2_key_fifo

Overview:
- Sits between the hps_io keyboard output (`ps2_key`, toggle-strobed, 11 bits) and the CPU-side input registers of `system`.
- Converts each toggle of `ps2_key[10]` into one queued key event, so the CPU never misses keystrokes that arrive faster than it polls.
- Maintains a held-key bitmap, so software can also query the live up/down state of any key.
- Runs entirely in the `clk_sys` domain.

Parameters:
- DEPTH, 16: FIFO entry count. Must be a power of two and at least 2.
- AW, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- clk_sys  in  1  system clock (24 MHz)
- reset  in  1  synchronous, active-high reset
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
- rd  in  1  pop strobe; one entry consumed per cycle while high and not empty
- dout  out  10  head entry {pressed, extended, scancode}; show-ahead
- empty  out  1  FIFO holds no entries
- count  out  AW+1  number of entries, 0..DEPTH
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- clr_overflow  in  1  clears `overflow`
- held_addr  in  9  {extended, scancode} to query
- held  out  1  1 if that key is currently down; registered, 1-cycle latency

Behaviour:
- Reset state:
  - Pointers = 0, `count` = 0, `empty` = 1.
  - `dout` = 0, `overflow` = 0, `held` = 0.
  - All 512 bitmap bits = 0.
  - Toggle reference `last_tog` <= `ps2_key[10]`, so the current toggle level is not treated as an event after reset.
- Event detection:
  - `ev` is registered: `ev` <= (`ps2_key[10]` != `last_tog`), and `ev_data` <= `ps2_key[9:0]`.
  - `last_tog` <= `ps2_key[10]` every non-reset cycle.
  - At most one event per cycle. Back-to-back toggles on consecutive cycles each produce an event.
- Push: on the cycle `ev`=1, `ev_data` is written at the write pointer if space is available.
  - Latency: toggle change at cycle N gives `ev` at N+1; `empty`=0, `count`/`dout` updated at N+2.
- Pop: when `rd`=1 and `empty`=0, the read pointer advances.
  - `rd` while empty is ignored; `count` stays 0 and no underflow occurs.
- `dout` = storage[rd_ptr]. It is driven from a register or distributed RAM read, and is valid whenever `empty`=0.
  - After a pop, the next entry appears on `dout` in the following cycle.
  - When `empty`=1, `dout` holds its last value (0 after reset).
- Simultaneous push and pop:
  - Not full: both occur and `count` is unchanged.
  - Full: the pop frees a slot, so the push is accepted, `count` stays DEPTH, and `overflow` is not set.
- Full without pop: the event is dropped, storage and pointers are unchanged, and `overflow` <= 1.
- Overflow priority: a set condition and `clr_overflow` in the same cycle leave `overflow`=1 (set wins).
- Pointers wrap modulo DEPTH. `count` is AW+1 bits so that full (DEPTH) and empty (0) are distinct.
- Held bitmap: on every `ev`, bit[{ev_data[8], ev_data[7:0]}] <= `ev_data[9]`.
  - The bitmap updates even when the FIFO push is dropped.
  - `held` <= bitmap[`held_addr`] each cycle. A same-cycle update and read of the same address returns the old value.
- Reset mid-operation: FIFO contents are discarded and the bitmap is cleared. A toggle landing in the same cycle as `reset` is absorbed into `last_tog` and produces no event.

Test Plan:
- Reset with `ps2_key[10]`=1, then release reset with no further toggle -> `empty`=1 and `count`=0 for 100 cycles, with no spurious event.
- Toggle with `ps2_key`={tog,1,0,8'h1C} at cycle N -> `empty` falls at N+2, `dout`=10'h21C, `count`=1; with `held_addr`=9'h01C, `held`=1 one cycle later.
- 20 toggles (16 presses followed by 4 releases of 8'h1C) with no `rd`, DEPTH=16 -> `count`=16, `overflow`=1, all 16 entries are the press events, and `held`(9'h01C)=0 (bitmap still updated).
- With the FIFO full, assert `rd` in the same cycle as the `ev` that follows a toggle -> `count` stays 16, `overflow` stays 0, and the new entry is the last one popped.
- Pulse `rd` 3 times when `count`=2 -> `count`=0, `empty`=1, no pointer corruption; a subsequent push reads back correctly.
- Assert `clr_overflow` in the same cycle as a dropped push -> `overflow` stays 1; `clr_overflow` alone on the next cycle -> `overflow`=0.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// Bundle of the keyboard-event FIFO signals between hps_io/system glue (master) and the FIFO (slave).
interface ps2_key_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [10:0] ps2_key;
  logic        rd;
  logic [9:0]  dout;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        clr_overflow;
  logic [8:0]  held_addr;
  logic        held;

  modport master (
    output ps2_key, rd, clr_overflow, held_addr,
    input  dout, empty, count, overflow, held
  );

  modport slave (
    input  ps2_key, rd, clr_overflow, held_addr,
    output dout, empty, count, overflow, held
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// Turns each toggle of ps2_key[10] into a queued key event and tracks a 512-bit held-key bitmap.
module ps2_key_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic           clk_sys,
  input logic           reset,
  ps2_key_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic              last_tog;
  logic              ev;
  logic [9:0]        ev_data;
  logic [9:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_ptr_nx;
  logic [AW:0]       cnt;
  logic [AW:0]       cnt_nx;
  logic [AW:0]       remain;
  logic              full;
  logic              pop;
  logic              push;
  logic              ovf_set;
  logic [9:0]        dout_q;
  logic [9:0]        dout_nx;
  logic              ovf_q;
  logic              held_q;
  logic [511:0]      held_map;

  // Read side: dout is the head whenever empty is low; rd pops one entry per
  // cycle only when empty is low, otherwise it is ignored. Write side has no
  // backpressure: an event arriving while full (and not popped) is dropped.
  always_comb begin
    full      = (cnt == FULL_CNT);
    pop       = bus.rd && (cnt != '0);
    push      = ev && (!full || pop);
    ovf_set   = ev && full && !pop;
    rd_ptr_nx = rd_ptr + AW'(pop);
    remain    = cnt - (AW+1)'(pop);
    cnt_nx    = cnt;
    if (push && !pop) begin
      cnt_nx = cnt + ONE_CNT;
    end else if (pop && !push) begin
      cnt_nx = cnt - ONE_CNT;
    end
    // Head register: bypass the incoming event when it lands in an otherwise empty queue.
    dout_nx = dout_q;
    if (push && (remain == '0)) begin
      dout_nx = ev_data;
    end else if (remain != '0) begin
      dout_nx = mem[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset && push) begin
      mem[wr_ptr] <= ev_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_tog <= bus.ps2_key[10];
      ev       <= 1'b0;
      ev_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      held_q   <= 1'b0;
      held_map <= '0;
    end else begin
      last_tog <= bus.ps2_key[10];
      ev       <= (bus.ps2_key[10] != last_tog);
      ev_data  <= bus.ps2_key[9:0];
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr_nx;
      cnt      <= cnt_nx;
      dout_q   <= dout_nx;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        ovf_q <= 1'b0;
      end
      // Bitmap tracks every event, even ones the queue had to drop.
      held_q <= held_map[bus.held_addr];
      if (ev) begin
        held_map[ev_data[8:0]] <= ev_data[9];
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.empty    = (cnt == '0);
  assign bus.count    = cnt;
  assign bus.overflow = ovf_q;
  assign bus.held     = held_q;

endmodule
